fmul_arbiter: RTL
=================

Name: fmul_arbiter

Overview:
- Shares one combinational single-precision multiplier (`fmul`: a, b, rm -> s) between N requesters.
- Each requester gets a valid/ready operand channel and a valid/ready result channel.
- Arbitration is round-robin; the multiplier output is sampled after a programmable multicycle window so the long combinational path meets timing.
- Sits between issue logic of several FP clients and the single `fmul` instance.

Parameters:
- N, 4, number of requesters (2..8).
- IDW, 2, width of grant index; N <= 2**IDW.
- MUL_CYCLES, 2, clock cycles allowed for the `fmul` combinational path (>=1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- clrn  in  1  reset; synchronous, active-low.
- req_valid  in  N  per-requester operand valid.
- req_a  in  32*N  operand a, requester i at bits [32i+31:32i].
- req_b  in  32*N  operand b, same packing.
- req_rm  in  2*N  rounding mode, requester i at bits [2i+1:2i].
- req_ready  out  N  per-requester operand accept.
- res_valid  out  N  per-requester result valid.
- res_ready  in  N  per-requester result accept.
- res_s  out  32  result value, shared bus; meaningful only when some res_valid bit is set.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  IDW  index of requester currently owning the unit.

Behaviour:
- Reset (clrn=0 at a clock edge):
  - state=IDLE; req_ready=0; res_valid=0; res_s=0; busy=0; grant_id=0.
  - Operand registers cleared; round-robin pointer last=N-1, so requester 0 has first priority.
  - Reset mid-operation abandons the op; no result is ever delivered for it.
- States: IDLE, CALC, DONE.
- IDLE:
  - Grant g is the first i with req_valid[i]=1, searching (last+1) mod N upward with wrap.
  - req_ready[g]=1 combinationally in the same cycle; all other req_ready bits are 0.
  - req_ready is 0 in CALC and DONE.
  - On that edge: latch req_a/b/rm of g into op regs, grant_id<=g, last<=g, cnt<=MUL_CYCLES-1, go to CALC.
  - No req_valid set: stay in IDLE.
- CALC:
  - `fmul` inputs are driven only from op regs, which are stable for the whole window.
  - cnt>0: cnt<=cnt-1.
  - cnt==0: res_s<=fmul.s, go to DONE.
- DONE:
  - res_valid[grant_id]=1; other res_valid bits are 0.
  - res_s is held constant.
  - On res_ready[grant_id]=1: go to IDLE. No new grant on that same edge.
  - res_ready on non-granted bits is ignored.
- Latency: operand handshake at edge k -> res_valid high from the cycle after edge k+MUL_CYCLES.
  - Minimum issue interval is MUL_CYCLES+2 cycles with res_ready tied high.
- Fairness: after g is served, g has the lowest priority in the next arbitration.
  - A continuously requesting client waits at most N-1 ops.
- Handshake rules:
  - Requesters must hold req_* stable while req_valid=1 and not accepted.
  - Dropping req_valid before acceptance is legal and has no side effect.
- Arithmetic: results are bit-identical to standalone `fmul` for the same a, b, rm, including NaN, inf, denormals and overflow per rm. The arbiter does no rounding of its own.

Test Plan:
1. Single op: reset, then req 0 with a=3fc00000, b=3fc00000, rm=0; res_ready[0]=1 -> res_valid[0] asserts exactly MUL_CYCLES+1 cycles after acceptance, res_s=40100000, busy high from the cycle after acceptance until the result handshake.
2. Round-robin: all 4 requesters valid continuously, each with distinct operands (i: a=40000000, b=3f800000+i<<20) -> grant order 0,1,2,3,0; each res_s matches a standalone `fmul` model; no requester served twice before the others.
3. Special values through arbiter:
   - req 2: 7f800000 * 00000000 -> 7fc00000.
   - req 1: 7f7fffff * 7f7fffff, rm=0 -> 7f800000.
   - req 3: 00800000 * 3f000000 -> 00400000.
4. Result backpressure: res_ready[1]=0 for 10 cycles with another requester valid -> res_valid[1] and res_s held stable, req_ready all 0, no new grant until res_ready[1]=1; next grant occurs one cycle after that handshake.
5. Reset mid-CALC: drive clrn=0 one cycle after acceptance -> no res_valid ever for that op; after release, requester 0 wins over a simultaneously valid requester 2.
6. Withdrawn request: req_valid[3] pulsed while unit in DONE, then dropped -> no grant to 3, no state change; MUL_CYCLES=1 build passes test 1 with latency of 2.

Source files
------------

// File: rtl/fmul_arbiter.sv
// fmul_arbiter: round-robin sharing of one combinational single-precision multiplier
// between N valid/ready requesters, with a multicycle window before the result is sampled.
module fmul (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  rm,
    output logic [31:0] s
);
    // rm: 0 nearest-even, 1 toward -inf, 2 toward +inf, 3 toward zero
    logic               sign, za, zb, ia, ib, nan, ovf, ovf_inf, g, st, inc;
    logic [7:0]         ea, eb, ef;
    logic [23:0]        ma, mb;
    logic [47:0]        p, pn;
    logic [95:0]        sh_v;
    logic [5:0]         lz, rsh;
    logic signed [10:0] e;
    logic [30:0]        mag;
    always_comb begin
        sign = a[31] ^ b[31];
        za   = a[30:0] == 31'd0;
        zb   = b[30:0] == 31'd0;
        ia   = a[30:23] == 8'hff && a[22:0] == 23'd0;
        ib   = b[30:23] == 8'hff && b[22:0] == 23'd0;
        nan  = (a[30:23] == 8'hff && a[22:0] != 23'd0) || (b[30:23] == 8'hff && b[22:0] != 23'd0)
               || (ia && zb) || (ib && za);
        ea   = a[30:23] == 8'd0 ? 8'd1 : a[30:23];
        eb   = b[30:23] == 8'd0 ? 8'd1 : b[30:23];
        ma   = {|a[30:23], a[22:0]};
        mb   = {|b[30:23], b[22:0]};
        p    = ma * mb;
        lz   = 6'd0;
        for (int i = 0; i < 48; i++) if (p[i]) lz = 6'(47 - i);
        pn   = p << lz;
        // e is the biased exponent once pn[47] is the hidden bit; e<=0 means subnormal
        e    = $signed({3'b0, ea}) + $signed({3'b0, eb}) - 11'sd126 - $signed({5'b0, lz});
        rsh  = e > 0 ? 6'd0 : (e < -11'sd46 ? 6'd48 : 6'(11'sd1 - e));
        sh_v = {pn, 48'd0} >> rsh;
        ef   = sh_v[95] ? e[7:0] : 8'd0;
        g    = sh_v[71];
        st   = |sh_v[70:0];
        inc  = rm == 2'd0 ? g & (st | sh_v[72]) :
               rm == 2'd1 ? sign & (g | st) :
               rm == 2'd2 ? ~sign & (g | st) : 1'b0;
        mag  = {ef, sh_v[94:72]} + 31'(inc);
        ovf  = e > 11'sd254;
        ovf_inf = rm == 2'd0 || (rm == 2'd1 && sign) || (rm == 2'd2 && !sign);
        s    = nan ? 32'h7fc00000 :
               (ia || ib) ? {sign, 8'hff, 23'd0} :
               (za || zb) ? {sign, 31'd0} :
               ovf ? (ovf_inf ? {sign, 8'hff, 23'd0} : {sign, 31'h7f7fffff}) :
               {sign, mag};
    end
endmodule

module fmul_arbiter #(
    parameter int N          = 4,
    parameter int IDW        = 2,
    parameter int MUL_CYCLES = 2
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic [N-1:0]    req_valid,
    input  logic [32*N-1:0] req_a,
    input  logic [32*N-1:0] req_b,
    input  logic [2*N-1:0]  req_rm,
    output logic [N-1:0]    req_ready,
    output logic [N-1:0]    res_valid,
    input  logic [N-1:0]    res_ready,
    output logic [31:0]     res_s,
    output logic            busy,
    output logic [IDW-1:0]  grant_id
);
    localparam int CW = MUL_CYCLES > 1 ? $clog2(MUL_CYCLES) : 1;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t         state_q, state_d;
    logic [IDW-1:0] last_q, last_d, gid_q, gid_d, g, idx;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    a_q, a_d, b_q, b_d, s_q, s_d, fs;
    logic [1:0]     rm_q, rm_d;
    logic           any;

    fmul u_fmul (.a(a_q), .b(b_q), .rm(rm_q), .s(fs));

    // Scan from farthest to nearest so the requester just after last wins
    always_comb begin
        g   = '0;
        idx = '0;
        any = 1'b0;
        for (int k = N; k >= 1; k--) begin
            idx = IDW'((int'(last_q) + k) % N);
            if (req_valid[idx]) begin
                g   = idx;
                any = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        gid_d     = gid_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        rm_d      = rm_q;
        s_d       = s_q;
        req_ready = '0;
        res_valid = '0;
        case (state_q)
            IDLE: if (any) begin
                req_ready[g] = 1'b1;
                a_d          = req_a[32*g +: 32];
                b_d          = req_b[32*g +: 32];
                rm_d         = req_rm[2*g +: 2];
                gid_d        = g;
                last_d       = g;
                cnt_d        = CW'(MUL_CYCLES - 1);
                state_d      = CALC;
            end
            CALC: if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
                  else begin
                      s_d     = fs;
                      state_d = DONE;
                  end
            DONE: begin
                res_valid[gid_q] = 1'b1;
                if (res_ready[gid_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q <= IDLE;
            last_q  <= IDW'(N - 1);
            gid_q   <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rm_q    <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gid_q   <= gid_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rm_q    <= rm_d;
            s_q     <= s_d;
        end
    end

    assign busy     = state_q != IDLE;
    assign grant_id = gid_q;
    assign res_s    = s_q;
endmodule
